// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with grant locking for a single-port data memory.
// Combinational grant and memory drive; responses registered one cycle after acceptance.
module dmem_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int LOCK_MAX  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [1:0]  req_lock,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        w_prio_nxt;
    logic [7:0]  r_lock_cnt;
    logic [7:0]  w_lock_cnt_nxt;
    logic [1:0]  r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [1:0]  w_grant;
    logic        w_sel;
    logic        w_accept;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_oor;
    logic        w_lock_sel;
    logic        w_owner;

    always_comb begin
        w_grant = 2'b00;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (req_valid == 2'b11) w_grant = r_prio ? 2'b10 : 2'b01;
                    else                    w_grant = req_valid;
                end
                LOCK0:   w_grant = {1'b0, req_valid[0]};
                LOCK1:   w_grant = {req_valid[1], 1'b0};
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_sel      = w_grant[1];
    assign w_accept   = |w_grant;
    assign w_addr     = w_sel ? req_addr1  : req_addr0;
    assign w_wdata    = w_sel ? req_wdata1 : req_wdata0;
    assign w_oor      = (w_addr >> ADDR_BITS) != 32'd0;
    assign w_lock_sel = req_lock[w_sel];
    assign w_owner    = (r_state == LOCK1);

    assign req_ready  = w_grant;
    assign mem_we     = w_accept & req_we[w_sel] & ~w_oor;
    assign mem_addr   = w_accept ? w_addr  : 32'd0;
    assign mem_wdata  = w_accept ? w_wdata : 32'd0;

    always_comb begin
        w_state_nxt    = r_state;
        w_prio_nxt     = r_prio;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_lock_sel) begin
                        w_state_nxt    = w_sel ? LOCK1 : LOCK0;
                        w_lock_cnt_nxt = 8'd0;
                    end else begin
                        w_prio_nxt = ~w_sel;
                    end
                end
            end
            LOCK0, LOCK1: begin
                w_lock_cnt_nxt = r_lock_cnt + 8'd1;
                // Forced release bounds the other port's wait even if the owner keeps locking.
                if ((r_lock_cnt == 8'(LOCK_MAX - 1)) || (w_accept && !w_lock_sel)) begin
                    w_state_nxt    = IDLE;
                    w_prio_nxt     = ~w_owner;
                    w_lock_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_lock_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_prio       <= 1'b0;
            r_lock_cnt   <= 8'd0;
            r_resp_valid <= 2'b00;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prio       <= w_prio_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_resp_valid <= w_grant;
            if (w_accept) begin
                // mem_rdata is sampled before the write lands, so writes return the old word.
                r_resp_rdata <= w_oor ? 32'd0 : mem_rdata;
                r_resp_err   <= w_oor;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
